// File: rtl/arb_requester.sv
// rtl/arb_requester.sv - queued burst requester toward a shared arbiter.
// Optional grant watchdog enabled by ARB_REQUESTER_TIMEOUT_EN.
module arb_requester #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        job_valid_i,
  input  logic [LEN_W-1:0]            job_len_i,
  output logic                        job_ready_o,
  output logic                        req_o,
  input  logic                        gnt_i,
  output logic                        beat_valid_o,
  output logic                        beat_last_o,
  output logic [LEN_W-1:0]            beat_idx_o,
`ifdef ARB_REQUESTER_TIMEOUT_EN
  output logic                        timeout_o,
`endif
  output logic [$clog2(FIFO_DEPTH):0] pending_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUSY, S_REL} state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     cnt_q;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic              req_q, req_d;
  logic              bv_q, bv_d, bl_q, bl_d;
  logic [LEN_W-1:0]  bi_q, bi_d;
  logic              push, pop;

  assign job_ready_o  = cnt_q < CW'(FIFO_DEPTH);
  assign push         = job_valid_i && job_ready_o;
  assign pop          = (state_q == S_IDLE) && (cnt_q != '0);
  assign pending_o    = cnt_q;
  assign req_o        = req_q;
  assign beat_valid_o = bv_q;
  assign beat_last_o  = bl_q;
  assign beat_idx_o   = bi_q;

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= job_len_i;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

`ifdef ARB_REQUESTER_TIMEOUT_EN
  logic [7:0] to_cnt_q, to_cnt_d;
  logic       to_q, to_d;
  assign timeout_o = to_q;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    len_d   = len_q;
    idx_d   = idx_q;
    bv_d    = 1'b0;
    bl_d    = 1'b0;
    bi_d    = '0;
`ifdef ARB_REQUESTER_TIMEOUT_EN
    to_cnt_d = '0;
    to_d     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) begin
          len_d   = mem_q[rd_ptr_q];
          idx_d   = '0;
          req_d   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (gnt_i) begin
          state_d = S_BUSY;
        end
`ifdef ARB_REQUESTER_TIMEOUT_EN
        else if (to_cnt_q == 8'd254) begin
          to_d    = 1'b1;
          req_d   = 1'b0;
          state_d = S_REL;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
`endif
      end
      S_BUSY: begin
        // Grant low is preemption: hold position and keep requesting.
        if (gnt_i) begin
          bv_d = 1'b1;
          bi_d = idx_q;
          bl_d = (idx_q == len_q);
          if (idx_q == len_q) begin
            req_d   = 1'b0;
            state_d = S_REL;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      len_q   <= '0;
      idx_q   <= '0;
      bv_q    <= 1'b0;
      bl_q    <= 1'b0;
      bi_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      bv_q    <= bv_d;
      bl_q    <= bl_d;
      bi_q    <= bi_d;
    end
  end

`ifdef ARB_REQUESTER_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_cnt_q <= '0;
      to_q     <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_q     <= to_d;
    end
  end
`endif
endmodule
